// File: rtl/pvr_vq_pkg.sv
// Shared types and helpers for the PVR VQ texel path: FSM states, codebook
// geometry and the 2x2 codebook-entry texel selector.
package pvr_vq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IDX_REQ  = 3'd1,
        ST_CB_PROBE = 3'd2,
        ST_CB_CHECK = 3'd3,
        ST_CB_FILL  = 3'd4,
        ST_OUT      = 3'd5
    } vq_state_e;

    localparam int CB_BYTES   = 2048;
    localparam int CB_ENTRIES = 256;
    localparam int CB_IDX_W   = $clog2(CB_ENTRIES);
    // Half-width of the twiddled offset: one bit per block-coordinate bit.
    localparam int TW_HALF    = 9;

    // sel = {u[0], v[0]} picks one of the four 16-bit texels of an entry.
    function automatic logic [15:0] texel_select(input logic [63:0] entry,
                                                 input logic [1:0]  sel);
        logic [15:0] r;
        case (sel)
            2'd0:    r = entry[15:0];
            2'd1:    r = entry[31:16];
            2'd2:    r = entry[47:32];
            2'd3:    r = entry[63:48];
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vq_twiddle.sv
// Combinational twiddle: interleaves block coordinates into a Morton offset,
// masked to the texture size. Shared with the non-VQ twiddled fetch path.
module vq_twiddle
    import pvr_vq_pkg::*;
(
    input  logic [TW_HALF-1:0]   bx,
    input  logic [TW_HALF-1:0]   by,
    input  logic [3:0]           size_log2,
    output logic [2*TW_HALF-1:0] t
);

    // Bit 2k from by[k], bit 2k+1 from bx[k], only for k < size_log2-1.
    always_comb begin
        t = {(2*TW_HALF){1'b0}};
        for (int k = 0; k < TW_HALF; k++) begin
            if ((k + 1) < int'(size_log2)) begin
                t[2*k]   = by[k];
                t[2*k+1] = bx[k];
            end else begin
                t[2*k]   = 1'b0;
                t[2*k+1] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vq_texel_fetch.sv
// VQ texel fetch: index byte from VRAM (with last-word reuse), codebook
// cache probe/fill, and hand-off of the selected texel to the filter.
module vq_texel_fetch
    import pvr_vq_pkg::*;
#(
    parameter int VRAM_AW = 23,
    parameter int UV_W    = 10
)
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [UV_W-1:0]      req_u,
    input  logic [UV_W-1:0]      req_v,
    input  logic [3:0]           req_size_log2,
    input  logic [VRAM_AW-1:0]   req_tex_base,
    input  logic [9:0]           req_tag,
    input  logic                 idx_flush,
    output logic                 vram_rd,
    output logic [VRAM_AW-4:0]   vram_addr,
    input  logic                 vram_valid,
    input  logic [63:0]          vram_din,
    output logic [9:0]           cb_tag,
    output logic [7:0]           cb_read_index,
    output logic                 cb_cache_read,
    input  logic                 cb_wait,
    input  logic                 cb_hit,
    input  logic [63:0]          cb_dout,
    output logic                 texel_valid,
    input  logic                 texel_ready,
    output logic [15:0]          texel
);

    localparam int WA_W = VRAM_AW - 3;

    vq_state_e             state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [9:0]            tag_q, tag_d;
    logic [WA_W-1:0]       waddr_q, waddr_d;
    logic [2:0]            lane_q, lane_d;
    logic [1:0]            sel_q, sel_d;
    logic [CB_IDX_W-1:0]   index_q, index_d;
    logic [15:0]           texel_q, texel_d;
    logic [63:0]           idx_word_q, idx_word_d;
    logic [WA_W-1:0]       idx_waddr_q, idx_waddr_d;
    logic                  idx_ok_q, idx_ok_d;
    logic                  fill_first_q, fill_first_d;

    logic                  vram_rd_s;
    logic                  cache_read_s;
    logic [TW_HALF-1:0]    bx_s, by_s;
    logic [2*TW_HALF-1:0]  twid_s;
    logic [VRAM_AW-1:0]    byte_addr_s;
    logic                  idx_reuse_s;

    // Block coordinates straight from the request; only sampled on accept.
    always_comb begin
        bx_s = TW_HALF'(req_u >> 1);
        by_s = TW_HALF'(req_v >> 1);
    end

    vq_twiddle u_twiddle (
        .bx        (bx_s),
        .by        (by_s),
        .size_log2 (req_size_log2),
        .t         (twid_s)
    );

    // Index bytes follow the 2 KB codebook; the sum wraps in VRAM space.
    assign byte_addr_s = req_tex_base + VRAM_AW'(CB_BYTES) + VRAM_AW'(twid_s);
    assign idx_reuse_s = idx_ok_q && !idx_flush &&
                         (idx_waddr_q == byte_addr_s[VRAM_AW-1:3]);

    // Next-state and datapath update for the fetch/probe/fill sequence.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        waddr_d      = waddr_q;
        lane_d       = lane_q;
        sel_d        = sel_q;
        index_d      = index_q;
        texel_d      = texel_q;
        idx_word_d   = idx_word_q;
        idx_waddr_d  = idx_waddr_q;
        idx_ok_d     = idx_ok_q;
        fill_first_d = fill_first_q;
        vram_rd_s    = 1'b0;
        cache_read_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rdy_q && req_valid) begin
                    tag_d   = req_tag;
                    waddr_d = byte_addr_s[VRAM_AW-1:3];
                    lane_d  = byte_addr_s[2:0];
                    sel_d   = {req_u[0], req_v[0]};
                    if (idx_reuse_s) begin
                        index_d = idx_word_q[{byte_addr_s[2:0], 3'b000} +: 8];
                        state_d = ST_CB_PROBE;
                    end else begin
                        state_d = ST_IDX_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDX_REQ: begin
                // The VRAM port is shared with the cache fill.
                vram_rd_s = !cb_wait;
                if (vram_rd_s && vram_valid) begin
                    idx_word_d  = vram_din;
                    idx_waddr_d = waddr_q;
                    idx_ok_d    = 1'b1;
                    index_d     = vram_din[{lane_q, 3'b000} +: 8];
                    state_d     = ST_CB_PROBE;
                end else begin
                    state_d = ST_IDX_REQ;
                end
            end
            ST_CB_PROBE: begin
                state_d = ST_CB_CHECK;
            end
            ST_CB_CHECK: begin
                if (cb_hit) begin
                    texel_d = texel_select(cb_dout, sel_q);
                    state_d = ST_OUT;
                end else begin
                    cache_read_s = 1'b1;
                    fill_first_d = 1'b1;
                    state_d      = ST_CB_FILL;
                end
            end
            ST_CB_FILL: begin
                // The first fill cycle never exits, so cb_wait has time to rise.
                if (fill_first_q) begin
                    fill_first_d = 1'b0;
                end else if (!cb_wait) begin
                    state_d = ST_CB_PROBE;
                end else begin
                    state_d = ST_CB_FILL;
                end
            end
            ST_OUT: begin
                if (texel_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush beats a same-cycle capture.
        if (idx_flush) begin
            idx_ok_d = 1'b0;
        end else begin
            idx_ok_d = idx_ok_d;
        end

        rdy_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rdy_q        <= 1'b0;
            tag_q        <= 10'd0;
            waddr_q      <= {WA_W{1'b0}};
            lane_q       <= 3'd0;
            sel_q        <= 2'd0;
            index_q      <= {CB_IDX_W{1'b0}};
            texel_q      <= 16'h0000;
            idx_word_q   <= 64'h0;
            idx_waddr_q  <= {WA_W{1'b0}};
            idx_ok_q     <= 1'b0;
            fill_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= rdy_d;
            tag_q        <= tag_d;
            waddr_q      <= waddr_d;
            lane_q       <= lane_d;
            sel_q        <= sel_d;
            index_q      <= index_d;
            texel_q      <= texel_d;
            idx_word_q   <= idx_word_d;
            idx_waddr_q  <= idx_waddr_d;
            idx_ok_q     <= idx_ok_d;
            fill_first_q <= fill_first_d;
        end
    end

    assign req_ready     = rdy_q;
    assign vram_rd       = vram_rd_s;
    assign vram_addr     = waddr_q;
    assign cb_tag        = tag_q;
    assign cb_read_index = index_q;
    assign cb_cache_read = cache_read_s;
    assign texel_valid   = (state_q == ST_OUT);
    assign texel         = texel_q;

endmodule
